// File: rtl/score_pkg.sv
// score_pkg: shared state encoding and default widths for the score sequencer
package score_pkg;
  typedef enum logic [1:0] {IDLE, GEN, FETCH, HOLD} seq_state_t;
  localparam int NOTE_W_DEF = 5;
  localparam int LEN_W_DEF = 2;
  localparam int ADDR_W_DEF = 6;
  localparam int NUM_BANKS_DEF = 2;
  localparam int REST_NOTE = 0;
endpackage

// File: rtl/score_ram.sv
// score_ram: single write port, synchronous read-enabled read port score memory
module score_ram #(
  parameter int DATA_W = 7,
  parameter int AW = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/score_sequencer.sv
// score_sequencer: multi-bank score store with beat-timed autonomous playback
module score_sequencer
  import score_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_BANKS = NUM_BANKS_DEF,
  localparam int BANK_W = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gen_start,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic              wr_valid,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              gen_done,
  input  logic              play_start,
  input  logic [BANK_W-1:0] play_bank,
  input  logic              loop,
  input  logic              play_stop,
  input  logic              beat_tick,
  output logic [NOTE_W-1:0] note,
  output logic [LEN_W-1:0]  length,
  output logic              playing,
  output logic              play_done,
  output logic              busy_gen
);
  localparam logic [ADDR_W-1:0] LAST = '1;
  seq_state_t state;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [LEN_W-1:0] beat_cnt;
  logic [NUM_BANKS-1:0] bank_valid;
  logic [BANK_W-1:0] gen_bank, cur_bank;
  logic show;
  logic [NOTE_W+LEN_W-1:0] rdata;
  logic [NOTE_W-1:0] rd_note;
  logic [LEN_W-1:0] rd_len;
  assign {rd_note, rd_len} = rdata;
  // read data stays captured through HOLD and the following FETCH, so outputs never glitch between notes
  assign note = show ? rd_note : NOTE_W'(REST_NOTE);
  assign length = show ? rd_len : '0;
  assign playing = (state == FETCH) || (state == HOLD);
  assign busy_gen = state == GEN;
  score_ram #(.DATA_W(NOTE_W + LEN_W), .AW(BANK_W + ADDR_W)) u_ram (
    .clk(clk),
    .we(state == GEN && wr_valid),
    .waddr({gen_bank, wr_ptr}),
    .wdata({wr_note, wr_len}),
    .re(state == FETCH),
    .raddr({cur_bank, rd_ptr}),
    .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      beat_cnt <= '0;
      bank_valid <= '0;
      gen_bank <= '0;
      cur_bank <= '0;
      gen_done <= 1'b0;
      play_done <= 1'b0;
      show <= 1'b0;
    end else begin
      play_done <= 1'b0;
      case (state)
        IDLE:
          if (gen_start) begin
            state <= GEN;
            wr_ptr <= '0;
            gen_bank <= wr_bank;
            bank_valid[wr_bank] <= 1'b0;
            gen_done <= 1'b0;
          end else if (play_start && bank_valid[play_bank]) begin
            state <= FETCH;
            rd_ptr <= '0;
            cur_bank <= play_bank;
          end
        GEN:
          if (wr_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == LAST) begin
              state <= IDLE;
              bank_valid[gen_bank] <= 1'b1;
              gen_done <= 1'b1;
            end
          end
        FETCH: begin
          state <= play_stop ? IDLE : HOLD;
          show <= !play_stop;
          beat_cnt <= '0;
        end
        HOLD:
          if (play_stop) begin
            state <= IDLE;
            show <= 1'b0;
          end else if (beat_tick) begin
            if (beat_cnt != rd_len) beat_cnt <= beat_cnt + 1'b1;
            else if (rd_ptr == LAST && !loop) begin
              state <= IDLE;
              show <= 1'b0;
              play_done <= 1'b1;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
              state <= FETCH;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_score_sequencer.sv
// tb_score_sequencer: directed checks of fill, playback timing, looping, stop and reset abort
module tb_score_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  logic gen_start = 1'b0, wr_bank = 1'b0, wr_valid = 1'b0;
  logic [4:0] wr_note = '0;
  logic [1:0] wr_len = '0;
  logic gen_done, play_start = 1'b0, play_bank = 1'b0, loop = 1'b0, play_stop = 1'b0, beat_tick = 1'b0;
  logic [4:0] note;
  logic [1:0] length;
  logic playing, play_done, busy_gen;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  score_sequencer dut (
    .clk(clk), .reset(reset), .gen_start(gen_start), .wr_bank(wr_bank), .wr_valid(wr_valid),
    .wr_note(wr_note), .wr_len(wr_len), .gen_done(gen_done), .play_start(play_start),
    .play_bank(play_bank), .loop(loop), .play_stop(play_stop), .beat_tick(beat_tick),
    .note(note), .length(length), .playing(playing), .play_done(play_done), .busy_gen(busy_gen)
  );
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic fill(input logic bank, input logic [1:0] len0);
    gen_start = 1'b1;
    wr_bank = bank;
    cyc;
    gen_start = 1'b0;
    chk("gen_busy", busy_gen, 1);
    chk("gen_done_cleared", gen_done, 0);
    for (int i = 0; i < 64; i++) begin
      wr_valid = 1'b1;
      wr_note = 5'((i + 1) % 32);
      wr_len = (i == 0) ? len0 : 2'd0;
      cyc;
      if (i == 62) chk("gen_done_early", gen_done, 0);
    end
    wr_valid = 1'b0;
    chk("gen_done_set", gen_done, 1);
    chk("gen_busy_low", busy_gen, 0);
  endtask
  task automatic play_all(input logic lp);
    play_bank = 1'b1;
    play_start = 1'b1;
    loop = lp;
    cyc;
    play_start = 1'b0;
    chk("fetch_playing", playing, 1);
    chk("fetch_note_rest", note, 0);
    cyc;
    for (int i = 0; i < 64; i++) begin
      chk("hold_note", note, (i + 1) % 32);
      chk("hold_len", length, 0);
      cyc;
      cyc;
      beat_tick = 1'b1;
      cyc;
      beat_tick = 1'b0;
      if (i < 63) begin
        chk("fetch_keep_note", note, (i + 1) % 32);
        chk("no_done_mid", play_done, 0);
        cyc;
      end
    end
    if (!lp) begin
      chk("end_done_pulse", play_done, 1);
      chk("end_playing", playing, 0);
      chk("end_note_rest", note, 0);
      cyc;
      chk("done_one_cycle", play_done, 0);
    end else begin
      chk("loop_no_done", play_done, 0);
      chk("loop_playing", playing, 1);
      cyc;
      chk("loop_wrap_note", note, 1);
      play_stop = 1'b1;
      cyc;
      play_stop = 1'b0;
      chk("loop_stop_playing", playing, 0);
      chk("loop_stop_no_done", play_done, 0);
      chk("loop_stop_note", note, 0);
    end
    loop = 1'b0;
  endtask
  initial begin
    cyc;
    cyc;
    reset = 1'b0;
    chk("rst_note", note, 0);
    chk("rst_length", length, 0);
    chk("rst_playing", playing, 0);
    chk("rst_play_done", play_done, 0);
    chk("rst_gen_done", gen_done, 0);
    chk("rst_busy_gen", busy_gen, 0);
    play_bank = 1'b0;
    play_start = 1'b1;
    cyc;
    play_start = 1'b0;
    chk("invalid_bank_ignored", playing, 0);
    chk("invalid_bank_note", note, 0);
    fill(1'b1, 2'd0);
    play_all(1'b0);
    fill(1'b0, 2'd3);
    play_bank = 1'b0;
    play_start = 1'b1;
    cyc;
    play_start = 1'b0;
    beat_tick = 1'b1;
    cyc;
    beat_tick = 1'b0;
    chk("len3_note", note, 1);
    chk("len3_length", length, 3);
    for (int t = 0; t < 3; t++) begin
      cyc;
      beat_tick = 1'b1;
      cyc;
      beat_tick = 1'b0;
      chk("len3_held", note, 1);
    end
    cyc;
    chk("len3_fetch_tick_ignored", note, 1);
    chk("len3_still_playing", playing, 1);
    beat_tick = 1'b1;
    cyc;
    beat_tick = 1'b0;
    chk("len3_fetch_keep", note, 1);
    cyc;
    chk("len3_next_note", note, 2);
    chk("len3_next_len", length, 0);
    play_stop = 1'b1;
    cyc;
    play_stop = 1'b0;
    chk("stop_playing", playing, 0);
    chk("stop_note", note, 0);
    chk("stop_no_done", play_done, 0);
    cyc;
    chk("stop_no_done_later", play_done, 0);
    play_all(1'b1);
    gen_start = 1'b1;
    wr_bank = 1'b0;
    play_start = 1'b1;
    play_bank = 1'b1;
    cyc;
    gen_start = 1'b0;
    chk("both_start_gen", busy_gen, 1);
    chk("both_start_not_playing", playing, 0);
    chk("both_start_gen_done_clr", gen_done, 0);
    cyc;
    play_start = 1'b0;
    chk("gen_ignores_play", busy_gen, 1);
    chk("gen_ignores_play_pl", playing, 0);
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_note = 5'(i + 3);
      cyc;
    end
    wr_valid = 1'b0;
    reset = 1'b1;
    cyc;
    reset = 1'b0;
    chk("reset_gen_abort", busy_gen, 0);
    chk("reset_gen_done", gen_done, 0);
    play_start = 1'b1;
    play_bank = 1'b0;
    cyc;
    play_start = 1'b0;
    chk("partial_bank_ignored", playing, 0);
    cyc;
    chk("partial_bank_note", note, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/score_sequencer.md
# score_sequencer

Multi-bank score store and playback sequencer, the parametrised successor to the single-score note/length memory. It holds `NUM_BANKS` independent scores, each with `2**ADDR_W` (note, length) entries, filled through a valid-qualified write port. It plays any filled bank back autonomously, holding each note for a beat-tick-counted duration, with optional looping and stop. It sits between the random score generator / keyboard capture logic and the audio/video note decoders.

## Interface
Parameters:
- `NOTE_W`, 5, note code width; code 0 = rest
- `LEN_W`, 2, length code width; hold duration = `len+1` beat ticks
- `ADDR_W`, 6, entries per bank = `2**ADDR_W`
- `NUM_BANKS`, 2, number of scores; `BANK_W = $clog2(NUM_BANKS)`, minimum 1

Ports:
- `clk` in 1: the single clock
- `reset` in 1: synchronous, active-high
- `gen_start` in 1: pulse; begin filling bank `wr_bank`
- `wr_bank` in `BANK_W`: target bank, sampled with `gen_start`
- `wr_valid` in 1: write one entry this cycle
- `wr_note` in `NOTE_W`, `wr_len` in `LEN_W`: entry data
- `gen_done` out 1: level; last fill completed; cleared by `gen_start` or `reset`
- `play_start` in 1: pulse; begin playback of `play_bank`
- `play_bank` in `BANK_W`: sampled with `play_start`
- `loop` in 1: sampled at each end-of-score
- `play_stop` in 1: abort playback
- `beat_tick` in 1: one-cycle pulse per beat unit
- `note` out `NOTE_W`, `length` out `LEN_W`: current note and its length code
- `playing` out 1: high in FETCH/HOLD
- `play_done` out 1: one-cycle pulse at non-looped end of score
- `busy_gen` out 1: high in GEN

## Operation
- Single FSM, states IDLE, GEN, FETCH, HOLD. Generation and playback are mutually exclusive.
- IDLE: `gen_start` → GEN, `wr_ptr` = 0, clear `bank_valid[wr_bank]` and `gen_done`. Otherwise, `play_start` with `bank_valid[play_bank]` = 1 → FETCH, `rd_ptr` = 0. `gen_start` wins if both are asserted. `play_start` on an invalid bank is ignored.
- GEN: each `wr_valid` writes entry `wr_ptr`, then increments it. Writing entry `2**ADDR_W-1` returns to IDLE, sets `bank_valid[bank]`, and sets `gen_done`. `play_start`, `gen_start` and `play_stop` are ignored in GEN.
- FETCH: one cycle for the synchronous RAM read of `rd_ptr` → HOLD. `note`/`length` keep their previous values during FETCH (no glitch between notes).
- HOLD: `note`/`length` show the registered read data. `beat_cnt` resets to 0 on entry and increments on `beat_tick`. A tick with `beat_cnt == length` ends the note:
  - If `rd_ptr == 2**ADDR_W-1` and `loop` = 0 → IDLE, `play_done` pulse.
  - If `rd_ptr == 2**ADDR_W-1` and `loop` = 1 → `rd_ptr` = 0, FETCH.
  - Else `rd_ptr`+1, FETCH.
- `play_stop` in FETCH/HOLD → IDLE next cycle, no `play_done`. `play_start` during playback is ignored.
- On entering IDLE from playback, `note` = 0 and `length` = 0.
- Pointer arithmetic is modulo `2**ADDR_W`. `beat_cnt` is `LEN_W` bits and never overflows, because it ends at `length`.

## Timing
- Reset values: state IDLE, `note` 0, `length` 0, `playing` 0, `play_done` 0, `gen_done` 0, `busy_gen` 0, all `bank_valid` 0, pointers 0. RAM contents are not reset.
- Write latency: entry written at the edge sampling `wr_valid`. `gen_done` is high in the cycle after the last write.
- Playback latency: with `play_start` sampled at edge N, the state is FETCH after N and `note` is valid after N+1. The same FETCH→HOLD latency of 1 cycle applies between notes.
- A note with code `L` lasts `L+1` ticks. `beat_tick` is ignored in FETCH, so the tick period must be ≥2 cycles.
- `reset` mid-GEN or mid-play aborts immediately. A partially written bank stays invalid.

## Structure
- Package `score_pkg`: state enum `seq_state_t`, default width constants, `REST_NOTE` = 0.
- Sub-module `score_ram`: one write port and one synchronous read port, `NUM_BANKS*2**ADDR_W` × (`NOTE_W`+`LEN_W`), addressed by {bank, ptr}. Instantiated once.
- The FSM, pointers, `beat_cnt` and `bank_valid` live in `score_sequencer`.

## Test plan
- Reset, then `play_start` on bank 0 → ignored; `playing` stays 0 and `note` = 0.
- `gen_start` on bank 1, then 64 writes with notes 1..64 mod 32 and len 0 → `gen_done` = 1 one cycle after the 64th write; `busy_gen` low.
- Play bank 1 with `loop` = 0 and a tick every 4 cycles → notes in write order, each held 1 tick; `play_done` pulses once after entry 63; `note` returns to 0.
- Entry with len 3 → `note` held exactly 4 ticks. A tick landing in FETCH is not counted.
- `loop` = 1 → `rd_ptr` wraps 63→0 with no `play_done`. `play_stop` mid-HOLD → IDLE next cycle, no `play_done`.
- `gen_start` and `play_start` in the same cycle → GEN is entered. `reset` mid-GEN, then `play_start` on that bank → ignored.
